// File: rtl/control_reloj.sv
// control_reloj: timekeeping and set-mode controller for the digital clock.
// A prescaler derives a one-second tick from clk, and the RUN/SET_H/SET_M mode machine
// is stepped by two debounced buttons. The optional alarm feature is enabled by defining
// CONTROL_RELOJ_ALARMA_EN. It adds the SET_AH/SET_AM modes, a 3-bit modo and the alarma
// output.
module control_reloj #(
  parameter int unsigned TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_modo,
  input  logic       btn_inc,
  output logic [4:0] horas,
  output logic [5:0] minutos,
  output logic [5:0] segundos,
`ifdef CONTROL_RELOJ_ALARMA_EN
  output logic [2:0] modo,
  output logic       alarma,
`else
  output logic [1:0] modo,
`endif
  output logic       ver_h,
  output logic       ver_m,
  output logic       tick_seg
);

  localparam int unsigned PrescW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PrescW-1:0] PrescMax  = PrescW'(TICKS_PER_SEC - 1);
  localparam logic [PrescW-1:0] PrescHalf = PrescW'(TICKS_PER_SEC / 2);

`ifdef CONTROL_RELOJ_ALARMA_EN
  typedef enum logic [2:0] {
    StRun = 3'd0, StSetH = 3'd1, StSetM = 3'd2, StSetAh = 3'd3, StSetAm = 3'd4
  } modo_e;
`else
  typedef enum logic [1:0] {StRun = 2'd0, StSetH = 2'd1, StSetM = 2'd2} modo_e;
`endif

  modo_e             estado;
  logic [PrescW-1:0] presc;
  logic              btn_modo_q, btn_inc_q;
  logic              tick, press_modo, press_inc;
  logic              blink_h, blink_m;
  logic [4:0]        horas_inc, run_h;
  logic [5:0]        minutos_inc, segundos_inc, run_m, run_s;
`ifdef CONTROL_RELOJ_ALARMA_EN
  logic [4:0]        al_h, al_h_inc;
  logic [5:0]        al_m, al_m_inc, al_cnt;
  logic              press_any, alarm_hit;
`endif

  assign modo = estado;

  // Decode tick, button edges, wrapped increments and the time after one RUN tick.
  always_comb begin
    tick         = (presc == PrescMax);
    press_modo   = btn_modo & ~btn_modo_q;
    // A simultaneous mode press swallows the increment press.
    press_inc    = btn_inc & ~btn_inc_q & ~press_modo;
    horas_inc    = (horas == 5'd23) ? 5'd0 : horas + 5'd1;
    minutos_inc  = (minutos == 6'd59) ? 6'd0 : minutos + 6'd1;
    segundos_inc = (segundos == 6'd59) ? 6'd0 : segundos + 6'd1;
    run_s        = segundos_inc;
    run_m        = (segundos == 6'd59) ? minutos_inc : minutos;
    run_h        = (segundos == 6'd59 && minutos == 6'd59) ? horas_inc : horas;
    blink_h      = (estado == StSetH);
    blink_m      = (estado == StSetM);
`ifdef CONTROL_RELOJ_ALARMA_EN
    blink_h      = blink_h | (estado == StSetAh);
    blink_m      = blink_m | (estado == StSetAm);
    al_h_inc     = (al_h == 5'd23) ? 5'd0 : al_h + 5'd1;
    al_m_inc     = (al_m == 6'd59) ? 6'd0 : al_m + 6'd1;
    press_any    = press_modo | (btn_inc & ~btn_inc_q);
    alarm_hit    = (estado == StRun) && tick && (segundos == 6'd59) &&
                   (run_h == al_h) && (run_m == al_m);
`endif
  end

  // Prescaler, button history, blink enables, mode machine and time registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado     <= StRun;
      presc      <= '0;
      btn_modo_q <= 1'b0;
      btn_inc_q  <= 1'b0;
      tick_seg   <= 1'b0;
      ver_h      <= 1'b1;
      ver_m      <= 1'b1;
      horas      <= 5'd0;
      minutos    <= 6'd0;
      segundos   <= 6'd0;
`ifdef CONTROL_RELOJ_ALARMA_EN
      al_h       <= 5'd0;
      al_m       <= 6'd0;
      al_cnt     <= 6'd0;
      alarma     <= 1'b0;
`endif
    end else begin
      btn_modo_q <= btn_modo;
      btn_inc_q  <= btn_inc;
      tick_seg   <= tick;
      presc      <= tick ? '0 : presc + PrescW'(1);
      ver_h      <= blink_h ? (presc < PrescHalf) : 1'b1;
      ver_m      <= blink_m ? (presc < PrescHalf) : 1'b1;
      case (estado)
        StRun: begin
          if (press_modo) estado <= StSetH;
          if (tick) begin
            segundos <= run_s;
            minutos  <= run_m;
            horas    <= run_h;
          end
        end
        StSetH: begin
          if (press_modo)     estado <= StSetM;
          else if (press_inc) horas  <= horas_inc;
        end
`ifdef CONTROL_RELOJ_ALARMA_EN
        StSetM: begin
          if (press_modo)     estado  <= StSetAh;
          else if (press_inc) minutos <= minutos_inc;
        end
        StSetAh: begin
          if (press_modo)     estado <= StSetAm;
          else if (press_inc) al_h   <= al_h_inc;
        end
        StSetAm: begin
          // Re-entering RUN restarts the current second from zero.
          if (press_modo) begin
            estado   <= StRun;
            segundos <= 6'd0;
            presc    <= '0;
          end else if (press_inc) begin
            al_m <= al_m_inc;
          end
        end
`else
        StSetM: begin
          // Re-entering RUN restarts the current second from zero.
          if (press_modo) begin
            estado   <= StRun;
            segundos <= 6'd0;
            presc    <= '0;
          end else if (press_inc) begin
            minutos <= minutos_inc;
          end
        end
`endif
        default: estado <= StRun;
      endcase
`ifdef CONTROL_RELOJ_ALARMA_EN
      // Alarm rings for 60 ticks unless any button press silences it first.
      if (press_any) begin
        alarma <= 1'b0;
      end else if (alarm_hit) begin
        alarma <= 1'b1;
        al_cnt <= 6'd0;
      end else if (alarma && tick) begin
        if (al_cnt == 6'd59) alarma <= 1'b0;
        al_cnt <= al_cnt + 6'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_control_reloj.sv
// Bench for control_reloj with TICKS_PER_SEC = 4: directed table, hand sequences for
// multi-cycle corners, and random stimulus checked against a seconds-of-day model.
module tb_control_reloj;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n, btn_modo, btn_inc;
  logic [4:0] horas;
  logic [5:0] minutos, segundos;
  logic [1:0] modo;
  logic       ver_h, ver_m, tick_seg;

  int checks = 0;
  int errors = 0;

  // Reference model state: time as seconds of day, mode as 0/1/2.
  int m_t, m_mode, m_presc, m_bmq, m_biq, m_tick, m_vh, m_vm;

  control_reloj #(.TICKS_PER_SEC(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_modo (btn_modo),
    .btn_inc  (btn_inc),
    .horas    (horas),
    .minutos  (minutos),
    .segundos (segundos),
    .modo     (modo),
    .ver_h    (ver_h),
    .ver_m    (ver_m),
    .tick_seg (tick_seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst; int bm; int bi; int pulse; int reps;
    int eh; int em; int es; int emodo;
  } row_t;

  row_t rows[13];

  function automatic row_t mk(int rst, int bm, int bi, int pulse, int reps,
                              int eh, int em, int es, int emodo);
    row_t r;
    r.rst = rst; r.bm = bm; r.bi = bi; r.pulse = pulse; r.reps = reps;
    r.eh = eh; r.em = em; r.es = es; r.emodo = emodo;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int r, input int bm, input int bi);
    int mp, ip, mn;
    if (r == 0) begin
      m_t = 0; m_mode = 0; m_presc = 0; m_bmq = 0; m_biq = 0;
      m_tick = 0; m_vh = 1; m_vm = 1;
    end else begin
      mp = (bm != 0 && m_bmq == 0) ? 1 : 0;
      ip = (bi != 0 && m_biq == 0 && mp == 0) ? 1 : 0;
      m_vh = (m_mode == 1) ? ((m_presc < T / 2) ? 1 : 0) : 1;
      m_vm = (m_mode == 2) ? ((m_presc < T / 2) ? 1 : 0) : 1;
      m_tick = (m_presc == T - 1) ? 1 : 0;
      m_presc = (m_presc + 1) % T;
      case (m_mode)
        0: begin
          if (m_tick != 0) m_t = (m_t + 1) % 86400;
          if (mp != 0) m_mode = 1;
        end
        1: begin
          if (mp != 0) m_mode = 2;
          else if (ip != 0) m_t = ((m_t / 3600 + 1) % 24) * 3600 + m_t % 3600;
        end
        default: begin
          if (mp != 0) begin
            m_mode = 0; m_t = m_t - m_t % 60; m_presc = 0;
          end else if (ip != 0) begin
            mn = (m_t / 60) % 60;
            m_t = m_t - mn * 60 + ((mn + 1) % 60) * 60;
          end
        end
      endcase
      m_bmq = bm; m_biq = bi;
    end
  endtask

  task automatic compare_model();
    check("model_horas", int'(horas), m_t / 3600);
    check("model_minutos", int'(minutos), (m_t / 60) % 60);
    check("model_segundos", int'(segundos), m_t % 60);
    check("model_modo", int'(modo), m_mode);
    check("model_ver_h", int'(ver_h), m_vh);
    check("model_ver_m", int'(ver_m), m_vm);
    check("model_tick_seg", int'(tick_seg), m_tick);
  endtask

  task automatic cycle(input int r, input int bm, input int bi);
    rst_n = (r != 0); btn_modo = (bm != 0); btn_inc = (bi != 0);
    @(posedge clk);
    model_step(r, bm, bi);
    #1;
    compare_model();
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s,
                            input int md);
    check({name, "_h"}, int'(horas), h);
    check({name, "_m"}, int'(minutos), m);
    check({name, "_s"}, int'(segundos), s);
    check({name, "_modo"}, int'(modo), md);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int k = 0; k < rows[i].reps; k++) begin
        cycle(rows[i].rst, rows[i].bm, rows[i].bi);
        if (rows[i].pulse != 0) cycle(1, 0, 0);
      end
      check_time($sformatf("row%0d", i), rows[i].eh, rows[i].em, rows[i].es, rows[i].emodo);
    end
  endtask

  initial begin
    int ones_m, ones_h;
    rows[0]  = mk(1, 0, 1, 1, 10,  0, 0, 7, 0);   // inc presses in RUN are ignored
    rows[1]  = mk(1, 0, 0, 0, 212, 0, 1, 0, 0);   // 240 cycles since release
    rows[2]  = mk(1, 1, 0, 1, 1,   0, 1, 0, 1);
    rows[3]  = mk(1, 0, 1, 1, 23,  23, 1, 0, 1);
    rows[4]  = mk(1, 1, 0, 1, 1,   23, 1, 0, 2);
    rows[5]  = mk(1, 0, 1, 1, 58,  23, 59, 0, 2);
    rows[6]  = mk(1, 1, 0, 1, 1,   23, 59, 0, 0);
    rows[7]  = mk(1, 1, 0, 1, 1,   0, 0, 0, 1);
    rows[8]  = mk(1, 0, 1, 1, 24,  0, 0, 0, 1);   // full hour wrap
    rows[9]  = mk(1, 0, 1, 0, 10,  1, 0, 0, 1);   // held inc counts once
    rows[10] = mk(1, 0, 0, 0, 1,   1, 0, 0, 1);
    rows[11] = mk(1, 0, 1, 1, 37,  1, 37, 0, 2);
    rows[12] = mk(0, 0, 0, 0, 1,   0, 0, 0, 0);   // reset mid SET_M

    rst_n = 1'b0; btn_modo = 1'b0; btn_inc = 1'b0;
    // Reset and tick_seg cadence.
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check_time("reset", 0, 0, 0, 0);
    check("reset_ver_h", int'(ver_h), 1);
    check("reset_ver_m", int'(ver_m), 1);
    check("reset_tick", int'(tick_seg), 0);
    for (int k = 1; k <= 8; k++) begin
      cycle(1, 0, 0);
      check($sformatf("tick_seg_c%0d", k), int'(tick_seg), (k % T == 0) ? 1 : 0);
    end

    run_rows(0, 6);

    // 23:59:00 freshly in RUN: rollover lands on a single edge.
    for (int k = 0; k < 238; k++) cycle(1, 0, 0);
    check_time("pre_roll", 23, 59, 59, 0);
    cycle(1, 0, 0);
    check_time("roll", 0, 0, 0, 0);

    run_rows(7, 10);

    // Simultaneous mode and inc presses in SET_H: mode wins.
    cycle(1, 1, 1);
    check_time("simul", 1, 0, 0, 2);
    ones_m = 0; ones_h = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1, 0, 0);
      ones_m += int'(ver_m);
      ones_h += int'(ver_h);
    end
    check("blink_ver_m_ones", ones_m, 4);
    check("blink_ver_h_ones", ones_h, 8);

    run_rows(11, 12);

    for (int k = 0; k < 8; k++) cycle(1, 0, 0);
    check_time("after_reset_run", 0, 0, 2, 0);

    // Random stimulus against the model.
    for (int k = 0; k < 4000; k++) begin
      cycle(($urandom_range(0, 299) == 0) ? 0 : 1,
            ($urandom_range(0, 19) == 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_reloj.md
Name: control_reloj

Overview:
Timekeeping and set-mode controller for the digital clock. It sequences the hours, minutes and seconds counters from a 1 Hz tick derived from the system clock. It runs a three-mode user FSM (RUN, SET_H, SET_M) driven by two buttons. It drives `horas` (0-23) into the hour 7-segment encoder, drives `minutos`/`segundos` to their encoders, and provides blink enables for the field being edited.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per second; must be at least 2. Prescaler width is clog2(TICKS_PER_SEC).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- btn_modo  in  1  mode button; level input, already synchronised and debounced.
- btn_inc  in  1  increment button; level input, already synchronised and debounced.
- horas  out  5  hours, 0-23, registered.
- minutos  out  6  minutes, 0-59, registered.
- segundos  out  6  seconds, 0-59, registered.
- modo  out  2  current mode: 0 = RUN, 1 = SET_H, 2 = SET_M.
- ver_h  out  1  hour display enable. Blinks in SET_H, otherwise 1.
- ver_m  out  1  minute display enable. Blinks in SET_M, otherwise 1.
- tick_seg  out  1  one-cycle pulse at each prescaler terminal count.

Behaviour:
- Reset (rst_n = 0 at a clk edge): horas = minutos = segundos = 0, modo = RUN, prescaler = 0, ver_h = ver_m = 1, tick_seg = 0, button history registers = 0.
- Prescaler:
  - Free-runs 0 .. TICKS_PER_SEC-1 and wraps to 0.
  - tick_seg = 1 for exactly the cycle after the prescaler holds TICKS_PER_SEC-1. Registered, so it pulses once every TICKS_PER_SEC cycles.
- Button edges:
  - Each button is registered once (btn_q).
  - A press is btn = 1 and btn_q = 0 at a clk edge; the action takes effect on that same edge.
  - A held button produces exactly one press.
- Simultaneous modo and inc presses: the modo press wins and the inc press is discarded.
- FSM:
  - RUN: modo press goes to SET_H. inc presses are ignored.
  - SET_H: modo press goes to SET_M. inc press: horas = (horas == 23) ? 0 : horas + 1.
  - SET_M: modo press goes to RUN. inc press: minutos = (minutos == 59) ? 0 : minutos + 1, with no carry into horas.
  - Illegal modo encoding (3) goes to RUN on the next edge.
- Time advance happens only in RUN, on tick cycles:
  - segundos increments; 59 wraps to 0 and carries into minutos.
  - minutos 59 wraps to 0 and carries into horas.
  - horas 23 wraps to 0.
  - All carries resolve on the same edge, so 23:59:59 becomes 00:00:00 in one cycle.
- In SET_H and SET_M, segundos is frozen and ticks do not advance time.
- Transition SET_M to RUN: segundos and prescaler are cleared to 0 on that edge. The first subsequent tick follows TICKS_PER_SEC cycles later.
- Blink:
  - In SET_H, ver_h = 1 while prescaler < TICKS_PER_SEC/2, else 0. In SET_M, ver_m follows the same rule.
  - The field not being edited has its enable held at 1. Both enables are 1 in RUN.
  - Both are registered (one cycle behind the prescaler).
- Reset mid-operation, in any mode: the reset values above are applied on that edge, and any pending press is discarded.
- Outputs never leave their legal ranges.

Optional Feature:
Macro: CONTROL_RELOJ_ALARMA_EN.
- With the macro defined:
  - Two extra modes are added: 3 = SET_AH, 4 = SET_AM, and modo widens to 3 bits.
  - The mode sequence becomes RUN, SET_H, SET_M, SET_AH, SET_AM, RUN.
  - SET_AH and SET_AM edit alarm registers al_h (0-23) and al_m (0-59) with the same wrap rules. Both reset to 0.
  - Time is frozen in the alarm-set modes.
  - New output alarma (1 bit): set at the RUN tick where horas == al_h, minutos == al_m and segundos becomes 0. Cleared by any button press or after 60 ticks. Reset value 0.
  - Blink in the alarm modes uses ver_h and ver_m respectively.
- Without the macro: no alarm registers, no alarma port, modo is 2 bits, and the behaviour is exactly as above.

Test Plan (TICKS_PER_SEC = 4):
1. Hold rst_n = 0 for 2 cycles, then release → 00:00:00, modo = 0, ver_h = ver_m = 1. tick_seg first pulses 4 cycles after release, then every 4 cycles.
2. Run 240 cycles in RUN → 00:01:00. inc presses during this run leave the time unchanged.
3. modo press, 23 inc presses, modo press, 59 inc presses, modo press → 23:59:00 in RUN. Then 240 cycles → 00:00:00 on a single edge.
4. In SET_H, 24 inc presses from 0 → horas = 0. btn_inc held high for 10 cycles → exactly +1.
5. In SET_H, btn_modo and btn_inc rise on the same edge → modo = SET_M, horas unchanged. ver_m toggles with period 4 cycles and ver_h = 1.
6. In SET_M with minutos = 37, assert rst_n = 0 for 1 cycle → modo = RUN, 00:00:00, subsequent ticks advance segundos normally.
